execute_cycle: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX register contents produced by decode_cycle.
- It applies operand forwarding, runs the ALU, resolves branches, and computes the branch target.
- It registers the results into the EX/MEM pipeline register, which feeds memory_cycle.

---
 rtl/execute_cycle.sv | 98 +++++++++
 tb/tb_execute_cycle.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RV32I execute stage: forwarding, ALU, branch resolve, EX/MEM register
module execute_cycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic [3:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      shamt;
  logic            zero;

  // Forward select 10 reads the EX/MEM register output, i.e. its pre-edge value
  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b0110: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'b0111: alu_result = src_a << shamt;
      4'b1000: alu_result = src_a >> shamt;
      4'b1001: alu_result = XLEN'($signed(src_a) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - directed scoreboard bench for execute_cycle
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] wd;
    logic [31:0] alu;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  execute_cycle #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    ALUControlE = 4'b0000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
    PCE = 0; PCPlus4E = 0; ResultW = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
  endtask

  task automatic push(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                      input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] alu);
    exp_t e;
    e.rw = rw; e.mw = mw; e.rs = rs; e.rd = rd; e.pc4 = pc4; e.wd = wd; e.alu = alu;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".RegWriteM"},   {31'd0, RegWriteM},  {31'd0, e.rw});
      chk({tag, ".MemWriteM"},   {31'd0, MemWriteM},  {31'd0, e.mw});
      chk({tag, ".ResultSrcM"},  {31'd0, ResultSrcM}, {31'd0, e.rs});
      chk({tag, ".RD_M"},        {27'd0, RD_M},       {27'd0, e.rd});
      chk({tag, ".PCPlus4M"},    PCPlus4M,            e.pc4);
      chk({tag, ".WriteDataM"},  WriteDataM,          e.wd);
      chk({tag, ".ALU_ResultM"}, ALU_ResultM,         e.alu);
    end
  endtask

  task automatic alu_step(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res);
    clr();
    ALUControlE = op; RD1_E = a; RD2_E = b;
    push(0, 0, 0, 5'd0, 32'h0, b, res);
    tick(tag);
  endtask

  initial begin
    clr();
    // Reset with busy inputs: everything registered must stay 0
    rst = 0;
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd9;
    RD1_E = 5; RD2_E = 7; PCPlus4E = 32'h44;
    push(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick("rst1");
    // Still in reset: forward 10 sources 0, branch logic stays live
    BranchE = 1; ALUControlE = 4'b0001; ForwardA_E = 2'b10; RD2_E = 0;
    PCE = 32'h10; Imm_Ext_E = 32'h20;
    #1;
    chk("rst_pcsrc", {31'd0, PCSrcE}, 32'd1);
    chk("rst_pctarget", PCTargetE, 32'h30);
    push(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick("rst2");

    rst = 1;
    clr();
    RD1_E = 5; RD2_E = 7; RD_E = 5'd1; RegWriteE = 1; PCPlus4E = 32'h8;
    push(1, 0, 0, 5'd1, 32'h8, 32'd7, 32'd12);
    tick("first_add");

    alu_step("add",  4'b0000, 32'h80000000, 32'd1, 32'h80000001);
    alu_step("sub",  4'b0001, 32'h80000000, 32'd1, 32'h7FFFFFFF);
    alu_step("and",  4'b0010, 32'h80000000, 32'd1, 32'h00000000);
    alu_step("or",   4'b0011, 32'h80000000, 32'd1, 32'h80000001);
    alu_step("xor",  4'b0100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
    alu_step("slt",  4'b0101, 32'h80000000, 32'd1, 32'd1);
    alu_step("sltu", 4'b0110, 32'h80000000, 32'd1, 32'd0);
    alu_step("sra",  4'b1001, 32'h80000000, 32'd1, 32'hC0000000);
    alu_step("srl",  4'b1000, 32'h80000000, 32'd1, 32'h40000000);
    alu_step("sll",  4'b0111, 32'd1, 32'd31, 32'h80000000);
    alu_step("sll_amt5", 4'b0111, 32'd1, 32'd33, 32'h00000002);

    // Undefined code yields 0, so a branch on it is taken
    clr();
    ALUControlE = 4'b1111; RD1_E = 32'h80000000; RD2_E = 1; BranchE = 1;
    #1;
    chk("undef_pcsrc", {31'd0, PCSrcE}, 32'd1);
    push(0, 0, 0, 5'd0, 32'h0, 32'd1, 32'd0);
    tick("undef");

    clr();
    ALUSrcE = 1; Imm_Ext_E = 32'hFFFFFFFC; RD1_E = 32'h100; RD2_E = 32'hAA; MemWriteE = 1;
    ResultSrcE = 1; PCPlus4E = 32'h1234;
    push(0, 1, 1, 5'd0, 32'h1234, 32'hAA, 32'hFC);
    tick("imm_store");

    clr();
    RD1_E = 3; RD2_E = 4;
    push(0, 0, 0, 5'd0, 32'h0, 32'd4, 32'd7);
    tick("fwd_n");
    clr();
    ForwardA_E = 2'b10; RD1_E = 32'h999; RD2_E = 1;
    push(0, 0, 0, 5'd0, 32'h0, 32'd1, 32'd8);
    tick("fwd_a10");
    clr();
    ForwardB_E = 2'b10; RD1_E = 2; RD2_E = 32'h777;
    push(0, 0, 0, 5'd0, 32'h0, 32'd8, 32'd10);
    tick("fwd_b10");
    clr();
    ForwardB_E = 2'b01; ResultW = 32'h55; ALUSrcE = 1; Imm_Ext_E = 32'h10; RD1_E = 2; RD2_E = 32'h77;
    push(0, 0, 0, 5'd0, 32'h0, 32'h55, 32'h12);
    tick("fwd_b01");
    clr();
    ForwardA_E = 2'b01; ResultW = 32'h100; RD1_E = 32'h3; RD2_E = 32'h1;
    push(0, 0, 0, 5'd0, 32'h0, 32'h1, 32'h101);
    tick("fwd_a01");
    clr();
    ForwardA_E = 2'b11; ForwardB_E = 2'b11; ResultW = 32'hDEAD; RD1_E = 6; RD2_E = 1;
    push(0, 0, 0, 5'd0, 32'h0, 32'd1, 32'd7);
    tick("fwd_11");

    clr();
    BranchE = 1; ALUControlE = 4'b0001; RD1_E = 9; RD2_E = 9; PCE = 32'h40; Imm_Ext_E = 32'hFFFFFFF8;
    #1;
    chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
    chk("beq_target", PCTargetE, 32'h38);
    push(0, 0, 0, 5'd0, 32'h0, 32'd9, 32'd0);
    tick("beq_eq");
    RD2_E = 8;
    #1;
    chk("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    push(0, 0, 0, 5'd0, 32'h0, 32'd8, 32'd1);
    tick("beq_ne");

    // Reset mid-stream discards the in-flight result; next edge captures fresh inputs
    clr();
    RegWriteE = 1; RD_E = 5'd5; RD1_E = 1; RD2_E = 1; PCPlus4E = 32'h20;
    push(1, 0, 0, 5'd5, 32'h20, 32'd1, 32'd2);
    tick("mid_pre");
    rst = 0;
    push(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick("mid_rst");
    rst = 1;
    RD_E = 5'd6; RD1_E = 2; RD2_E = 3;
    push(1, 0, 0, 5'd6, 32'h20, 32'd3, 32'd5);
    tick("mid_post");

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
